// File: rtl/lock_pkg.sv
// Shared types and constants for the lock key sequencer and the benches that drive
// the downstream lock.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam int SYM_W = 2;
  localparam logic [SYM_W-1:0] SYM_IDLE = 2'b00;
  localparam logic [11:0] REF_KEY = 12'b011001100101;

  // Counter width helper: never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lock_key_sequencer.sv
// Plays a captured key into the FSM lock one 2-bit symbol per clock (MSB symbol
// first), then watches the lock's unlock flag for a bounded window.
module lock_key_sequencer
  import lock_pkg::*;
#(
  parameter int NSYM    = 6,
  parameter int TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SYM_W*NSYM-1:0] key,
  input  logic                  unlock,
  output logic                  inp0,
  output logic                  inp1,
  output logic                  busy,
  output logic                  done,
  output logic                  pass
);

  localparam int KEY_W  = SYM_W * NSYM;
  localparam int SCNT_W = cnt_w(NSYM);
  localparam int WCNT_W = cnt_w(TIMEOUT);
  localparam logic [SCNT_W-1:0] SYM_LAST  = SCNT_W'(NSYM - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  state_t             state_r, state_s;
  logic [KEY_W-1:0]   shreg_r, shreg_s;
  logic [SCNT_W-1:0]  scnt_r, scnt_s;
  logic [WCNT_W-1:0]  wcnt_r, wcnt_s;
  logic [SYM_W-1:0]   sym_r, sym_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               pass_r, pass_s;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_r <= {KEY_W{1'b0}};
      scnt_r  <= {SCNT_W{1'b0}};
      wcnt_r  <= {WCNT_W{1'b0}};
      sym_r   <= SYM_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      shreg_r <= shreg_s;
      scnt_r  <= scnt_s;
      wcnt_r  <= wcnt_s;
      sym_r   <= sym_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
    end
  end

  // Next-state and next-register values.
  // The symbol output is registered, so symbol 0 is loaded straight from key on the
  // accepting edge and the shift register runs one symbol ahead of the pins.
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    scnt_s  = scnt_r;
    wcnt_s  = wcnt_r;
    sym_s   = SYM_IDLE;
    busy_s  = busy_r;
    done_s  = 1'b0;
    pass_s  = pass_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          shreg_s = key << SYM_W;
          sym_s   = key[KEY_W-1 -: SYM_W];
          scnt_s  = {SCNT_W{1'b0}};
          wcnt_s  = {WCNT_W{1'b0}};
          busy_s  = 1'b1;
          pass_s  = 1'b0;
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (scnt_r == SYM_LAST) begin
          wcnt_s  = {WCNT_W{1'b0}};
          state_s = WAIT;
        end else begin
          sym_s   = shreg_r[KEY_W-1 -: SYM_W];
          shreg_s = shreg_r << SYM_W;
          scnt_s  = scnt_r + SCNT_W'(1);
        end
      end
      WAIT: begin
        if (unlock) begin
          pass_s  = 1'b1;
          done_s  = 1'b1;
          state_s = DONE;
        end else if (wcnt_r == WAIT_LAST) begin
          pass_s  = 1'b0;
          done_s  = 1'b1;
          state_s = DONE;
        end else begin
          wcnt_s  = wcnt_r + WCNT_W'(1);
        end
      end
      DONE: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        shreg_s = {KEY_W{1'b0}};
        scnt_s  = {SCNT_W{1'b0}};
        wcnt_s  = {WCNT_W{1'b0}};
        busy_s  = 1'b0;
        pass_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  assign inp0 = sym_r[1];
  assign inp1 = sym_r[0];
  assign busy = busy_r;
  assign done = done_r;
  assign pass = pass_r;

endmodule

// File: tb/tb_lock_key_sequencer.sv
// Directed bench for lock_key_sequencer with a small behavioural stand-in for the
// downstream lock (registered unlock after the reference key is seen).
module tb_lock_key_sequencer;
  import lock_pkg::*;

  localparam int NSYM    = 6;
  localparam int TIMEOUT = 4;
  localparam logic [11:0] WRONG_KEY = 12'b011001100100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] key = 12'h000;
  logic        unlock;
  logic        inp0, inp1, busy, done, pass;

  logic [11:0] hist;
  logic        lock_unl;
  logic        force_en = 1'b0;
  logic        force_val = 1'b0;

  int total = 0;
  int bad   = 0;

  lock_key_sequencer #(.NSYM(NSYM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .unlock(unlock),
    .inp0(inp0), .inp1(inp1), .busy(busy), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  // Lock stand-in: samples a symbol each edge, raises a registered unlock on a match.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist     <= 12'h000;
      lock_unl <= 1'b0;
    end else begin
      hist     <= {hist[9:0], inp0, inp1};
      lock_unl <= ({hist[9:0], inp0, inp1} == REF_KEY);
    end
  end

  assign unlock = force_en ? force_val : lock_unl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a run at the current negedge and returns at the negedge where done is seen.
  // disturb: re-pulse start with a different key during SEND and during WAIT.
  // early: hold unlock high through SEND, low through WAIT.
  task automatic run(input string tag, input logic [11:0] k, input int exp_lat,
                     input logic exp_pass, input bit disturb, input bit early);
    int lat;
    lat   = 0;
    start = 1'b1;
    key   = k;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        chk({tag, ".busy_on"}, 32'(busy), 32'd1);
        chk({tag, ".pass_clr"}, 32'(pass), 32'd0);
      end
      if (n <= NSYM)
        chk($sformatf("%s.sym%0d", tag, n - 1), 32'({inp0, inp1}),
            32'({k[13 - 2*n], k[12 - 2*n]}));
      if (n == NSYM + 1)
        chk({tag, ".wait_sym"}, 32'({inp0, inp1}), 32'd0);
      if (disturb) begin
        if (n == 3 || n == NSYM + 2) begin
          start = 1'b1;
          key   = REF_KEY;
        end else begin
          start = 1'b0;
        end
      end
      if (early) begin
        force_en  = 1'b1;
        force_val = (n <= NSYM);
      end
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    start    = 1'b0;
    force_en = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".pass"}, 32'(pass), 32'(exp_pass));
    chk({tag, ".busy_in_done"}, 32'(busy), 32'd1);
  endtask

  // Watches a few idle cycles: no further done pulses and busy stays low.
  task automatic quiet(input string tag);
    int dones;
    int busys;
    dones = 0;
    busys = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (busy === 1'b1) busys++;
    end
    chk({tag, ".extra_done"}, 32'(dones), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busys), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.inp", 32'({inp0, inp1}), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.pass", 32'(pass), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Reset mid-SEND after symbol 2.
    start = 1'b1;
    key   = REF_KEY;
    @(negedge clk);
    start = 1'b0;
    chk("mid.sym0", 32'({inp0, inp1}), 32'h1);
    @(negedge clk);
    chk("mid.sym1", 32'({inp0, inp1}), 32'h2);
    @(negedge clk);
    chk("mid.sym2", 32'({inp0, inp1}), 32'h1);
    chk("mid.busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid.rst_inp", 32'({inp0, inp1}), 32'd0);
    chk("mid.rst_busy", 32'(busy), 32'd0);
    chk("mid.rst_done", 32'(done), 32'd0);
    chk("mid.rst_pass", 32'(pass), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    quiet("mid.no_resume");

    // Correct key after reset replays from symbol 0.
    run("good", REF_KEY, NSYM + 2, 1'b1, 1'b0, 1'b0);
    quiet("good");

    // Wrong key times out.
    run("wrong", WRONG_KEY, NSYM + TIMEOUT + 1, 1'b0, 1'b0, 1'b0);
    quiet("wrong");

    // Start pulses and key changes while busy are ignored.
    run("busy", WRONG_KEY, NSYM + TIMEOUT + 1, 1'b0, 1'b1, 1'b0);
    quiet("busy");

    // Back-to-back: wrong then correct, busy low for one cycle between runs.
    run("b2b1", WRONG_KEY, NSYM + TIMEOUT + 1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b.gap_busy", 32'(busy), 32'd0);
    chk("b2b.gap_done", 32'(done), 32'd0);
    chk("b2b.gap_pass", 32'(pass), 32'd0);
    run("b2b2", REF_KEY, NSYM + 2, 1'b1, 1'b0, 1'b0);
    quiet("b2b2");

    // Unlock asserted only during SEND is ignored.
    run("early", WRONG_KEY, NSYM + TIMEOUT + 1, 1'b0, 1'b0, 1'b1);
    quiet("early");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
